input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/score4_pkg.sv | 30 +++
 rtl/button_debounce.sv | 62 ++++++
 rtl/input_conditioner.sv | 69 ++++++
 tb/tb_input_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
// Shared types and constants for the score4 board: action triple and debounce default.
package score4_pkg;

   localparam int unsigned DEBOUNCE_DEFAULT = 32'd500000;

   typedef struct packed {
      logic left;
      logic right;
      logic put;
   } lrp_t;

   localparam lrp_t LRP_NONE = '{left: 1'b0, right: 1'b0, put: 1'b0};

   // One-hot pick among simultaneous candidates: put wins, then left, then right.
   function automatic lrp_t lrp_pick(input logic l, input logic r, input logic p);
      lrp_t res;
      res = LRP_NONE;
      if (p) begin
         res.put = 1'b1;
      end else if (l) begin
         res.left = 1'b1;
      end else if (r) begin
         res.right = 1'b1;
      end else begin
         res = LRP_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw push-button: two-flop synchronizer, stable-level debounce counter,
// and a registered single-cycle pulse on each accepted 0->1 transition.
module button_debounce
   import score4_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise,
   output logic busy_next
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          prev_q;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter runs while the synchronized level disagrees; the final count flips the level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = {CW{1'b0}};
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = {CW{1'b0}};
         end else begin
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_d = {CW{1'b0}};
      end
      rise_d    = stable_q & ~prev_q;
      busy_next = (cnt_d != {CW{1'b0}});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= {CW{1'b0}};
      end else begin
         sync1_q  <= btn;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Turns local bouncing buttons and opponent link lines into one-hot action pulses,
// with put > left > right priority applied independently on each side.
module input_conditioner
   import score4_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left,
   input  logic       right,
   input  logic       put,
   input  logic       opp_left,
   input  logic       opp_right,
   input  logic       opp_put,
   output logic [2:0] self_lrp,
   output logic [2:0] opp_lrp,
   output logic       self_busy
);

   logic rise_l, rise_r, rise_p;
   logic busy_l, busy_r, busy_p;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
      .clk(clk), .rst(rst), .btn(left),  .rise(rise_l), .busy_next(busy_l));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
      .clk(clk), .rst(rst), .btn(right), .rise(rise_r), .busy_next(busy_r));
   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_put (
      .clk(clk), .rst(rst), .btn(put),   .rise(rise_p), .busy_next(busy_p));

   lrp_t opp_sync1_q, opp_sync2_q, opp_prev_q;
   lrp_t opp_rise_q, opp_rise_d;
   lrp_t self_lrp_q, self_lrp_d;
   lrp_t opp_lrp_q, opp_lrp_d;
   logic self_busy_q, self_busy_d;

   // Opponent lines are clean, so a synchronized rising edge is already an action.
   always_comb begin
      opp_rise_d  = opp_sync2_q & ~opp_prev_q;
      opp_lrp_d   = lrp_pick(opp_rise_q.left, opp_rise_q.right, opp_rise_q.put);
      self_lrp_d  = lrp_pick(rise_l, rise_r, rise_p);
      self_busy_d = busy_l | busy_r | busy_p;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opp_sync1_q <= LRP_NONE;
         opp_sync2_q <= LRP_NONE;
         opp_prev_q  <= LRP_NONE;
         opp_rise_q  <= LRP_NONE;
         opp_lrp_q   <= LRP_NONE;
         self_lrp_q  <= LRP_NONE;
         self_busy_q <= 1'b0;
      end else begin
         opp_sync1_q <= '{left: opp_left, right: opp_right, put: opp_put};
         opp_sync2_q <= opp_sync1_q;
         opp_prev_q  <= opp_sync2_q;
         opp_rise_q  <= opp_rise_d;
         opp_lrp_q   <= opp_lrp_d;
         self_lrp_q  <= self_lrp_d;
         self_busy_q <= self_busy_d;
      end
   end

   assign self_lrp  = self_lrp_q;
   assign opp_lrp   = opp_lrp_q;
   assign self_busy = self_busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DEBOUNCE_CYCLES=4): a history-based
// model checks every output each cycle, plus literal pins for key cycles.
module tb_input_conditioner;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic left = 1'b0, right = 1'b0, put = 1'b0;
   logic opp_left = 1'b0, opp_right = 1'b0, opp_put = 1'b0;
   logic [2:0] self_lrp, opp_lrp;
   logic       self_busy;

   int vectors = 0;
   int miscompares = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .left(left), .right(right), .put(put),
      .opp_left(opp_left), .opp_right(opp_right), .opp_put(opp_put),
      .self_lrp(self_lrp), .opp_lrp(opp_lrp), .self_busy(self_busy)
   );

   always #5 clk = ~clk;

   // raw samples per edge since reset release: 0 left,1 right,2 put,3..5 opp l/r/p
   bit hist [0:5][0:4095];
   bit rose [0:2][0:4095];
   bit st   [0:2];
   int n = 0;
   int k_m;
   bit prev_m, flip_m, busy_m;
   logic [2:0] exp_self, exp_opp;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   function automatic bit raw_at(input int b, input int i);
      if (i < 0) return 1'b0;
      return hist[b][i];
   endfunction

   function automatic logic [2:0] pick(input bit l, input bit r, input bit p);
      if (p) return 3'b001;
      if (l) return 3'b100;
      if (r) return 3'b010;
      return 3'b000;
   endfunction

   function automatic bit opp_rise(input int b, input int k);
      return raw_at(b, k - 3) && !raw_at(b, k - 4);
   endfunction

   // Model: a level is accepted after D consecutive synchronized samples disagree with it.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         n = 0;
         st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
         chk("reset_self_lrp", self_lrp, 3'b000);
         chk("reset_opp_lrp", opp_lrp, 3'b000);
         chk("reset_busy", {2'b00, self_busy}, 3'b000);
      end else if (n < 4096) begin
         k_m = n;
         hist[0][k_m] = left;     hist[1][k_m] = right;     hist[2][k_m] = put;
         hist[3][k_m] = opp_left; hist[4][k_m] = opp_right; hist[5][k_m] = opp_put;
         busy_m = 1'b0;
         for (int b = 0; b < 3; b++) begin
            prev_m = st[b];
            flip_m = 1'b1;
            for (int j = k_m - D - 1; j <= k_m - 2; j++)
               if (raw_at(b, j) == prev_m) flip_m = 1'b0;
            if (flip_m) st[b] = ~prev_m;
            rose[b][k_m] = flip_m && !prev_m;
            if (!flip_m && (raw_at(b, k_m - 2) != prev_m)) busy_m = 1'b1;
         end
         exp_self = (k_m >= 2) ? pick(rose[0][k_m-2], rose[1][k_m-2], rose[2][k_m-2]) : 3'b000;
         exp_opp  = pick(opp_rise(3, k_m), opp_rise(4, k_m), opp_rise(5, k_m));
         chk("model_self_lrp", self_lrp, exp_self);
         chk("model_opp_lrp", opp_lrp, exp_opp);
         chk("model_busy", {2'b00, self_busy}, {2'b00, busy_m});
         n = n + 1;
      end
   end

   task automatic set_in(input logic l, input logic r, input logic p,
                         input logic ol, input logic orr, input logic op);
      left = l; right = r; put = p;
      opp_left = ol; opp_right = orr; opp_put = op;
   endtask

   task automatic enter_reset(input logic ol);
      @(negedge clk);
      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, ol, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   task automatic idle(input int c);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (c) @(negedge clk);
   endtask

   logic [4:0] bounce;

   initial begin
      repeat (3) @(negedge clk);
      chk("lit_reset_busy", {2'b00, self_busy}, 3'b000);

      // clean put press held 20 cycles, then a short gap that must not re-trigger
      enter_reset(1'b0);
      rst = 1'b1; set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      chk("lit_put_pulse_c7", self_lrp, 3'b001);
      repeat (12) @(negedge clk);
      put = 1'b0;
      repeat (2) @(negedge clk);
      put = 1'b1;
      repeat (12) @(negedge clk);
      idle(12);

      // left bouncing 1,0,1,0,1 then held
      enter_reset(1'b0);
      rst = 1'b1;
      @(negedge clk);
      bounce = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
         left = bounce[i];
         @(negedge clk);
      end
      repeat (7) @(negedge clk);
      chk("lit_left_after_bounce", self_lrp, 3'b100);
      repeat (8) @(negedge clk);
      idle(12);

      // left and put together: put wins, left discarded
      enter_reset(1'b0);
      rst = 1'b1; set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (15) @(negedge clk);
      idle(12);

      // opponent right and local left on the same edge
      enter_reset(1'b0);
      rst = 1'b1; set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("lit_opp_right_c3", opp_lrp, 3'b010);
      repeat (4) @(negedge clk);
      chk("lit_self_left_c7", self_lrp, 3'b100);
      repeat (10) @(negedge clk);
      idle(12);

      // right held across a mid-count reset
      enter_reset(1'b0);
      rst = 1'b1; set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("lit_right_after_reset", self_lrp, 3'b010);
      repeat (10) @(negedge clk);
      idle(12);

      // short put press: busy but no pulse
      enter_reset(1'b0);
      rst = 1'b1; set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("lit_busy_c2", {2'b00, self_busy}, 3'b001);
      put = 1'b0;
      repeat (3) @(negedge clk);
      chk("lit_busy_c5", {2'b00, self_busy}, 3'b000);
      idle(12);

      // opp line high across reset release
      enter_reset(1'b1);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("lit_opp_left_hold", opp_lrp, 3'b100);
      idle(8);

      // simultaneous candidates on both sides, opponent and local pulses overlapping
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (15) @(negedge clk);
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
